// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared widths, segment codes and converter state for the score display
package seg_display_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int BIN_W = 14;
  localparam int BCD_W = 16;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_CODE [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    return d > 4'd9 ? SEG_BLANK : SEG_CODE[d];
  endfunction
endpackage

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble, one add-3/shift iteration per cycle
module bin_to_bcd_seq
  import seg_display_pkg::*;
(
  input  logic             clock_100mhz,
  input  logic             reset_n,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);
  conv_state_t state, state_nx;
  logic [BIN_W-1:0] bin;
  logic [3:0] iter;
  logic [BCD_W-1:0] adj;
  always_ff @(posedge clock_100mhz)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && start) state_nx = SHIFT;
    else if (state == SHIFT && iter == 4'(BIN_W - 1)) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  always_comb begin
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_ff @(posedge clock_100mhz)
    if (!reset_n) begin
      bcd <= '0;
      bin <= '0;
      iter <= '0;
    end else if (state == IDLE && start) begin
      bcd <= '0;
      bin <= value;
      iter <= '0;
    end else if (state == SHIFT) begin
      {bcd, bin} <= {adj[BCD_W-2:0], bin, 1'b0};
      iter <= iter + 4'd1;
    end
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: rtl/score_seg_display.sv
// score_seg_display: saturating BCD conversion and multiplexed 4-digit seven-segment drive
module score_seg_display
  import seg_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 250,
  parameter int MAX_VALUE   = 9999
) (
  input  logic             clock_100mhz,
  input  logic             reset_n,
  input  logic [BIN_W-1:0] value,
  input  logic             value_valid,
  input  logic             leading_zero_en,
  input  logic             blank,
  input  logic             blink_en,
  output logic [7:0]       seg,
  output logic [3:0]       an,
  output logic             busy,
  output logic             overflow
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int KW = $clog2(BLINK_DIV + 1);
  localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VALUE);
  logic [RW-1:0] ref_cnt;
  logic [1:0] idx;
  logic [KW-1:0] blink_cnt;
  logic phase_on, pending, ovf_q, start, conv_done, tc, wrap;
  logic [BIN_W-1:0] pend_val, src, sat;
  logic [BCD_W-1:0] bcd, digits, shifted;
  logic [7:0] seg_nx;
  logic [3:0] an_nx;
  assign start = !busy && (value_valid || pending);
  assign src = value_valid ? value : pend_val;
  assign sat = src > MAX_BIN ? MAX_BIN : src;
  bin_to_bcd_seq u_conv (
    .clock_100mhz(clock_100mhz),
    .reset_n(reset_n),
    .start(start),
    .value(sat),
    .busy(busy),
    .done(conv_done),
    .bcd(bcd)
  );
  // displayed digits and overflow only move on the DONE edge, so a scan never sees a half result
  always_ff @(posedge clock_100mhz)
    if (!reset_n) begin
      pending <= 1'b0;
      pend_val <= '0;
      ovf_q <= 1'b0;
      overflow <= 1'b0;
      digits <= '0;
    end else begin
      if (busy && value_valid) begin
        pending <= 1'b1;
        pend_val <= value;
      end else if (start) pending <= 1'b0;
      if (start) ovf_q <= src > MAX_BIN;
      if (conv_done) begin
        digits <= bcd;
        overflow <= ovf_q;
      end
    end
  assign tc = ref_cnt == RW'(REFRESH_DIV - 1);
  assign wrap = tc && idx == 2'd3;
  always_ff @(posedge clock_100mhz)
    if (!reset_n) begin
      ref_cnt <= '0;
      idx <= '0;
    end else begin
      ref_cnt <= tc ? '0 : ref_cnt + RW'(1);
      if (tc) idx <= idx + 2'd1;
    end
  always_ff @(posedge clock_100mhz)
    if (!reset_n || !blink_en) begin
      blink_cnt <= '0;
      phase_on <= 1'b1;
    end else if (wrap) begin
      blink_cnt <= blink_cnt == KW'(BLINK_DIV - 1) ? '0 : blink_cnt + KW'(1);
      if (blink_cnt == KW'(BLINK_DIV - 1)) phase_on <= ~phase_on;
    end
  // a digit is a leading zero when it and everything above it is zero
  always_comb begin
    shifted = digits >> {idx, 2'b00};
    seg_nx = (leading_zero_en && idx != 2'd0 && shifted == '0) ? SEG_BLANK
           : seg_code(shifted[3:0]) & {~(overflow && idx == 2'd0), 7'h7F};
    an_nx = ~(4'b0001 << idx);
    if (blank || (blink_en && !phase_on)) begin
      seg_nx = SEG_BLANK;
      an_nx = 4'hF;
    end
  end
  always_ff @(posedge clock_100mhz)
    if (!reset_n) begin
      seg <= SEG_BLANK;
      an <= 4'hF;
    end else begin
      seg <= seg_nx;
      an <= an_nx;
    end
endmodule

// File: tb/tb_score_seg_display.sv
// tb_score_seg_display: vector table, random values vs arithmetic model, and timing corner sequences
module tb_score_seg_display;
  localparam int RD = 4;
  localparam int BD = 2;
  logic clock_100mhz = 1'b0;
  logic reset_n = 1'b0;
  logic value_valid = 1'b0;
  logic leading_zero_en = 1'b0;
  logic blank = 1'b0;
  logic blink_en = 1'b0;
  logic [13:0] value = '0;
  logic [7:0] seg;
  logic [3:0] an;
  logic busy, overflow;
  int passed = 0;
  int total = 0;
  typedef struct {
    int v;
    bit lz;
    bit ovf;
    logic [31:0] s;
  } vec_t;
  vec_t vecs [10];
  logic [7:0] codes [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  score_seg_display #(.REFRESH_DIV(RD), .BLINK_DIV(BD), .MAX_VALUE(9999)) dut (
    .clock_100mhz(clock_100mhz),
    .reset_n(reset_n),
    .value(value),
    .value_valid(value_valid),
    .leading_zero_en(leading_zero_en),
    .blank(blank),
    .blink_en(blink_en),
    .seg(seg),
    .an(an),
    .busy(busy),
    .overflow(overflow)
  );

  always #5 clock_100mhz = ~clock_100mhz;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] model_seg(input int v, input bit lz, input int i);
    int d = v > 9999 ? 9999 : v;
    int p = 1;
    for (int k = 0; k < i; k++) p *= 10;
    if (lz && i > 0 && d / p == 0) return 8'hFF;
    return codes[(d / p) % 10] & ((v > 9999 && i == 0) ? 8'h7F : 8'hFF);
  endfunction

  task automatic pulse(input int v);
    value = 14'(v);
    value_valid = 1'b1;
    @(negedge clock_100mhz);
    value_valid = 1'b0;
  endtask

  task automatic convert(input int v, input string nm);
    int n = 0;
    pulse(v);
    while (busy && n < 40) begin
      n++;
      @(negedge clock_100mhz);
    end
    chk({nm, " busy cycles"}, n, 15);
    @(negedge clock_100mhz);
  endtask

  task automatic check_display(input logic [31:0] es, input bit eo, input string nm);
    logic [3:0] seen = 4'h0;
    int pos;
    chk({nm, " overflow"}, int'(overflow), int'(eo));
    for (int k = 0; k < 16; k++) begin
      pos = an == 4'hE ? 0 : an == 4'hD ? 1 : an == 4'hB ? 2 : an == 4'h7 ? 3 : -1;
      if (pos < 0) chk({nm, " anode"}, int'(an), 4'hE);
      else begin
        chk($sformatf("%s seg%0d", nm, pos), int'(seg), int'(es[8*pos +: 8]));
        seen[pos] = 1'b1;
      end
      @(negedge clock_100mhz);
    end
    chk({nm, " digits seen"}, int'(seen), 4'hF);
  endtask

  task automatic random_test();
    logic [31:0] es;
    int v;
    bit lz;
    for (int r = 0; r < 16; r++) begin
      v = $urandom_range(0, 16383);
      lz = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) es[8*i +: 8] = model_seg(v, lz, i);
      leading_zero_en = lz;
      convert(v, $sformatf("rand%0d v=%0d", r, v));
      check_display(es, v > 9999, $sformatf("rand%0d v=%0d", r, v));
    end
  endtask

  task automatic pending_test();
    leading_zero_en = 1'b0;
    pulse(1111);
    repeat (2) @(negedge clock_100mhz);
    pulse(2222);
    @(negedge clock_100mhz);
    pulse(3333);
    repeat (10) @(negedge clock_100mhz);
    chk("pend gap busy", int'(busy), 0);
    @(negedge clock_100mhz);
    chk("pend restart busy", int'(busy), 1);
    check_display(32'hF9F9F9F9, 1'b0, "pend first");
    chk("pend second done busy", int'(busy), 0);
    check_display(32'hB0B0B0B0, 1'b0, "pend latest");
    chk("pend no third conversion", int'(busy), 0);
  endtask

  task automatic blink_test();
    bit dark [200];
    int a = -1;
    int b = -1;
    int c = -1;
    int n = 0;
    blink_en = 1'b1;
    for (int k = 0; k < 200; k++) begin
      dark[k] = an == 4'hF;
      @(negedge clock_100mhz);
    end
    for (int k = 1; k < 200; k++) begin
      if (dark[k] && !dark[k-1]) begin
        if (a < 0) a = k;
        else if (b >= 0 && c < 0) c = k;
      end
      if (!dark[k] && dark[k-1] && a >= 0 && b < 0) b = k;
    end
    chk("blink first dark within 2 scans", int'(a >= 1 && a <= 34), 1);
    chk("blink dark run", b - a, 32);
    chk("blink lit run", c - b, 32);
    while (an != 4'hF && n < 80) begin
      n++;
      @(negedge clock_100mhz);
    end
    chk("blink dark found", int'(an), 4'hF);
    blink_en = 1'b0;
    @(negedge clock_100mhz);
    chk("blink disable relights", int'(an != 4'hF), 1);
  endtask

  task automatic blank_test();
    repeat (3) @(negedge clock_100mhz);
    blank = 1'b1;
    @(negedge clock_100mhz);
    chk("blank an", int'(an), 4'hF);
    chk("blank seg", int'(seg), 8'hFF);
    convert(4321, "blank conv");
    chk("blank still dark", int'(an), 4'hF);
    blank = 1'b0;
    @(negedge clock_100mhz);
    check_display(32'h99B0A4F9, 1'b0, "after blank 4321");
  endtask

  task automatic reset_mid_test();
    convert(15000, "pre-reset ovf");
    chk("pre-reset overflow", int'(overflow), 1);
    pulse(8888);
    repeat (5) @(negedge clock_100mhz);
    reset_n = 1'b0;
    @(negedge clock_100mhz);
    chk("mid reset seg", int'(seg), 8'hFF);
    chk("mid reset an", int'(an), 4'hF);
    chk("mid reset busy", int'(busy), 0);
    chk("mid reset overflow", int'(overflow), 0);
    reset_n = 1'b1;
    @(negedge clock_100mhz);
    check_display(32'hC0C0C0C0, 1'b0, "after mid reset");
    chk("after mid reset busy", int'(busy), 0);
  endtask

  initial begin
    vecs = '{
      '{1234,  1'b0, 1'b0, 32'hF9A4B099},
      '{7,     1'b1, 1'b0, 32'hFFFFFFF8},
      '{0,     1'b1, 1'b0, 32'hFFFFFFC0},
      '{1005,  1'b1, 1'b0, 32'hF9C0C092},
      '{50,    1'b1, 1'b0, 32'hFFFF92C0},
      '{9999,  1'b0, 1'b0, 32'h90909090},
      '{10000, 1'b0, 1'b1, 32'h90909010},
      '{12000, 1'b0, 1'b1, 32'h90909010},
      '{16383, 1'b0, 1'b1, 32'h90909010},
      '{5,     1'b0, 1'b0, 32'hC0C0C092}
    };
    repeat (3) @(negedge clock_100mhz);
    chk("reset seg", int'(seg), 8'hFF);
    chk("reset an", int'(an), 4'hF);
    chk("reset busy", int'(busy), 0);
    chk("reset overflow", int'(overflow), 0);
    reset_n = 1'b1;
    @(negedge clock_100mhz);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("scan an k=%0d", k), int'(an), int'(4'(~(4'b0001 << (k / 4)))));
      chk($sformatf("scan seg k=%0d", k), int'(seg), 8'hC0);
      chk($sformatf("scan busy k=%0d", k), int'(busy), 0);
      @(negedge clock_100mhz);
    end
    for (int i = 0; i < 10; i++) begin
      leading_zero_en = vecs[i].lz;
      convert(vecs[i].v, $sformatf("vec%0d v=%0d", i, vecs[i].v));
      check_display(vecs[i].s, vecs[i].ovf, $sformatf("vec%0d v=%0d", i, vecs[i].v));
    end
    random_test();
    pending_test();
    blink_test();
    blank_test();
    reset_mid_test();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/score_seg_display.md
Name: score_seg_display

Overview:
- Downstream stage producing the seven-segment drive (seg/an) that the top-level muxes in while the game is active.
- Takes a binary score from game logic and converts it to BCD with a sequential double-dabble engine, one iteration per cycle.
- Time-multiplexes the four Basys3 digits, with leading-zero suppression, blanking, blink and overflow indication.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); minimum 2.
- BLINK_DIV, 250, full digit slots per blink half-period.
- MAX_VALUE, 9999, saturation limit for the displayed value.

Ports:
- clock_100mhz  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- value  in  14  binary score to display
- value_valid  in  1  single-cycle strobe; value is sampled on the same edge
- leading_zero_en  in  1  1 = blank leading zeros; digit 0 is always shown
- blank  in  1  1 = all digits off
- blink_en  in  1  1 = blink the whole display
- seg  out  8  active-low segments {dp,g,f,e,d,c,b,a}
- an  out  4  active-low anodes; an[0] is the rightmost digit
- busy  out  1  conversion in progress
- overflow  out  1  last accepted value exceeded MAX_VALUE

Behaviour:
- Reset (reset_n=0 at an edge): seg=8'hFF, an=4'hF, busy=0, overflow=0, displayed digits=0000, pending cleared, refresh counter=0, scan index=0, blink phase=on, FSM=IDLE. Reset mid-conversion aborts it; the displayed digits become 0.
- Converter FSM: IDLE -> SHIFT -> DONE -> IDLE.
  - IDLE, value_valid sampled at edge N: capture sat = min(value, MAX_VALUE) and ovf = (value > MAX_VALUE). Clear the 16-bit BCD shift register and go to SHIFT.
  - SHIFT: 14 iterations, one per cycle, on edges N+1..N+14. Each iteration adds 3 to every BCD nibble >= 5, then shifts {bcd, bin} left by 1.
  - DONE, edge N+15: copy the BCD result into the displayed digits, set overflow=ovf, go to IDLE.
  - busy is high in cycles N+1..N+15 and low from N+16.
- Pending buffer:
  - value_valid while busy: the value is stored in a 1-entry pending register; a newer valid overwrites it (latest wins).
  - On entering IDLE with pending set, a new conversion starts on the next edge as if value_valid were sampled there, and pending is cleared.
  - value_valid on the DONE edge also goes to pending.
- Scanner:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - On terminal count, scan index advances 0->1->2->3->0 and the counter wraps to 0.
  - an = ~(4'b0001 << idx); seg = code(digit[idx]).
- Codes (dp off): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90.
- Leading-zero suppression: when leading_zero_en=1, digit i (i>0) is blanked (seg=FF, its anode stays asserted) if digit i and all higher digits are 0.
- Overflow: when overflow=1, the dp of digit 0 is lit (seg[7]=0 while idx=0); the display shows 9999.
- Blink:
  - A blink counter increments on each scan index wrap to 0 (i.e. once per 4 digit slots) and toggles the blink phase every BLINK_DIV wraps.
  - blink_en=1 with phase off gives seg=FF, an=F.
  - While blink_en=0, phase is held at on and the counter is held at 0.
- blank=1 forces seg=FF, an=F the cycle after it is sampled; the scanner and converter keep running.
- Timing: seg and an are registered, lagging idx/digit by one cycle. The displayed digits change only on the DONE edge, so no torn digits.
- Width rules: value is 14-bit unsigned; 9999 fits; values 10000..16383 saturate.

Decomposition:
- Package seg_display_pkg:
  - NUM_DIGITS=4, BIN_W=14, BCD_W=16, SEG_BLANK=8'hFF, the 10-entry SEG_CODE constant array, and the converter state enum {IDLE, SHIFT, DONE}.
- Sub-module bin_to_bcd_seq:
  - Sequential double-dabble with start/value in and busy/done/bcd out.
  - The top handles the pending buffer, saturation, scanning and blink.

Test Plan (REFRESH_DIV=4, BLINK_DIV=2 in simulation):
- Reset release, no input -> an cycles E,D,B,7 every 4 clocks; seg=C0 on all digits; busy=0.
- value=1234 pulsed at edge N -> busy high in cycles N+1..N+15; from N+16, digit codes are an=E:99, D:B0, B:A4, 7:F9.
- value=7, leading_zero_en=1 -> digit0 seg=F8; digits 1-3 seg=FF; value=0 shows C0 on digit 0 only.
- value=12000 -> overflow=1; display 9999 (90 on all digits); digit 0 seg=10 (dp lit); then value=5 -> overflow=0.
- value=1111 then 2222 and 3333 at N+3 and N+5 -> 1111 shown after N+15; 3333 shown after its own 15-cycle conversion; 2222 never displayed.
- blink_en=1 -> display is dark for 2 full scans and on for 2, repeating; blank=1 mid-scan -> an=F next cycle; reset_n=0 mid-conversion -> seg=FF, an=F, busy=0, then 0 shown after release.
